arilla_bus_arbiter: RTL and testbench

Two-master arbiter that shares one arilla bus slave port between the hart memory path (master 0, core) and the debug module system-bus-access path (master 1, debug).
It grants one whole transaction at a time and routes the response back to the granted master only.
Policy is round-robin; an input forces debug priority while the hart is halted.
It sits between rv_core/debug module and the system interconnect.

---
 rtl/arilla_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_arilla_bus_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/arilla_bus_arbiter.sv
// arilla_bus_arbiter: two-master arbiter for one arilla bus slave port.
// Master 0 is the hart memory path (core); master 1 is debug system-bus access.
// A grant covers one whole transaction. The response goes only to the granted master.
// Arbitration is round-robin. dbg_priority forces the debug master to win.
// Optional feature: define ARILLA_BUS_ARBITER_TIMEOUT_EN to fault a grant that waits
// TimeoutCycles cycles without a slave ack.
module arilla_bus_arbiter #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dbg_priority,
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [2:0]           m0_size,
    input  logic [AddrWidth-1:0] m0_addr,
    input  logic [DataWidth-1:0] m0_wdata,
    output logic                 m0_ack,
    output logic [DataWidth-1:0] m0_rdata,
    output logic                 m0_fault,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [2:0]           m1_size,
    input  logic [AddrWidth-1:0] m1_addr,
    input  logic [DataWidth-1:0] m1_wdata,
    output logic                 m1_ack,
    output logic [DataWidth-1:0] m1_rdata,
    output logic                 m1_fault,
    output logic                 s_req,
    output logic                 s_we,
    output logic [2:0]           s_size,
    output logic [AddrWidth-1:0] s_addr,
    output logic [DataWidth-1:0] s_wdata,
    input  logic                 s_ack,
    input  logic [DataWidth-1:0] s_rdata,
    input  logic                 s_fault,
    output logic                 busy,
    output logic                 grant_id
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT0  = 2'd1;
    localparam logic [1:0] ST_GNT1  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("arilla_bus_arbiter: TimeoutCycles must be >= 1");
    end

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic       grant_id_q, grant_id_d;
    logic       in_gnt;
    logic       sel;
    logic       timeout_hit;
    logic       done;

    assign in_gnt = (state_q == ST_GNT0) || (state_q == ST_GNT1);
    assign sel    = (state_q == ST_GNT1);
    assign done   = in_gnt && (s_ack || timeout_hit);

`ifdef ARILLA_BUS_ARBITER_TIMEOUT_EN
    // Counter only needs to reach TimeoutCycles-1; clamp its width to 8..32 bits.
    localparam int CntBits = $clog2(TimeoutCycles + 1);
    localparam int CntW    = (CntBits < 8) ? 8 : ((CntBits > 32) ? 32 : CntBits);

    logic [CntW-1:0] cnt_q;

    // Count grant cycles without an ack. The counter sits at zero outside a grant,
    // so it is cleared on every entry to GNTx.
    always_ff @(posedge clk) begin
        if (rst || !in_gnt) begin
            cnt_q <= '0;
        end else if (!s_ack) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The Nth grant cycle (count N-1) without an ack is the timeout cycle.
    assign timeout_hit = in_gnt && !s_ack && (cnt_q == CntW'(TimeoutCycles - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Route request fields to the slave, and route the response back to the granted
    // master only.
    always_comb begin
        s_req    = 1'b0;
        s_we     = 1'b0;
        s_size   = '0;
        s_addr   = '0;
        s_wdata  = '0;
        m0_ack   = 1'b0;
        m0_rdata = '0;
        m0_fault = 1'b0;
        m1_ack   = 1'b0;
        m1_rdata = '0;
        m1_fault = 1'b0;
        if (in_gnt) begin
            // If a master drops req mid-grant (a protocol error), s_req follows it low.
            s_req   = (sel ? m1_req : m0_req) && !timeout_hit;
            s_we    = sel ? m1_we    : m0_we;
            s_size  = sel ? m1_size  : m0_size;
            s_addr  = sel ? m1_addr  : m0_addr;
            s_wdata = sel ? m1_wdata : m0_wdata;
            if (sel) begin
                m1_ack   = done;
                m1_rdata = s_ack ? s_rdata : '0;
                m1_fault = s_ack ? s_fault : timeout_hit;
            end else begin
                m0_ack   = done;
                m0_rdata = s_ack ? s_rdata : '0;
                m0_fault = s_ack ? s_fault : timeout_hit;
            end
        end
    end

    // Next-state logic. Arbitration happens only in IDLE, so a change of dbg_priority
    // during a grant waits for the next decision.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_id_d = grant_id_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_req && m1_req) begin
                    if (dbg_priority || !last_q) begin
                        state_d    = ST_GNT1;
                        last_d     = 1'b1;
                        grant_id_d = 1'b1;
                    end else begin
                        state_d    = ST_GNT0;
                        last_d     = 1'b0;
                        grant_id_d = 1'b0;
                    end
                end else if (m0_req) begin
                    state_d    = ST_GNT0;
                    last_d     = 1'b0;
                    grant_id_d = 1'b0;
                end else if (m1_req) begin
                    state_d    = ST_GNT1;
                    last_d     = 1'b1;
                    grant_id_d = 1'b1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (done) begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. After reset last = 1, so the core wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            grant_id_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign busy     = in_gnt;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// tb_arilla_bus_arbiter: directed self-checking bench for arilla_bus_arbiter.
// The bench drives inputs 1 ns after the rising edge.
// It samples outputs after a further 1 ns settle.
module tb_arilla_bus_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_priority;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [2:0]  m0_size, m1_size, s_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_fault, m1_ack, m1_fault;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_ack, s_fault;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        busy, grant_id;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    arilla_bus_arbiter #(
        .AddrWidth(32), .DataWidth(32), .TimeoutCycles(4)
    ) dut (
        .clk(clk), .rst(rst), .dbg_priority(dbg_priority),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_fault(m0_fault),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_fault(m1_fault),
        .s_req(s_req), .s_we(s_we), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata), .s_fault(s_fault),
        .busy(busy), .grant_id(grant_id)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction, starting in IDLE with the request already presented.
    // The slave acks in the first grant cycle.
    task automatic do_txn(input logic exp_id, input logic exp_we, input logic [31:0] rd,
                          input logic flt);
        tick();
        check_eq("txn grant_id", {31'd0, grant_id}, {31'd0, exp_id});
        check_eq("txn busy", {31'd0, busy}, 32'd1);
        check_eq("txn s_req", {31'd0, s_req}, 32'd1);
        check_eq("txn s_addr", s_addr, exp_id ? A1 : A0);
        check_eq("txn s_we", {31'd0, s_we}, {31'd0, exp_we});
        s_ack = 1'b1; s_rdata = rd; s_fault = flt;
        #1;
        check_eq("txn m0_ack", {31'd0, m0_ack}, {31'd0, ~exp_id});
        check_eq("txn m1_ack", {31'd0, m1_ack}, {31'd0, exp_id});
        check_eq("txn m0_rdata", m0_rdata, exp_id ? 32'd0 : rd);
        check_eq("txn m1_rdata", m1_rdata, exp_id ? rd : 32'd0);
        check_eq("txn m0_fault", {31'd0, m0_fault}, {31'd0, ~exp_id & flt});
        check_eq("txn m1_fault", {31'd0, m1_fault}, {31'd0, exp_id & flt});
        tick();
        s_ack = 1'b0; s_rdata = '0; s_fault = 1'b0;
        #1;
        check_eq("drain busy", {31'd0, busy}, 32'd0);
        check_eq("drain s_req", {31'd0, s_req}, 32'd0);
        check_eq("drain grant_id", {31'd0, grant_id}, {31'd0, exp_id});
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; dbg_priority = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_size = 3'b010; m0_addr = A0; m0_wdata = 32'h1111_0000;
        m1_req = 1'b0; m1_we = 1'b0; m1_size = 3'b010; m1_addr = A1; m1_wdata = 32'h2222_0000;
        s_ack = 1'b0; s_rdata = '0; s_fault = 1'b0;
        repeat (2) tick();
        check_eq("rst busy", {31'd0, busy}, 32'd0);
        check_eq("rst s_req", {31'd0, s_req}, 32'd0);
        check_eq("rst grant_id", {31'd0, grant_id}, 32'd0);
        check_eq("rst s_addr", s_addr, 32'd0);
        check_eq("rst acks", {30'd0, m0_ack, m1_ack}, 32'd0);

        // Single core read, slave answers in the third grant cycle.
        rst = 1'b0; m0_req = 1'b1;
        #1;
        check_eq("lat s_req idle", {31'd0, s_req}, 32'd0);
        tick();
        check_eq("lat s_req gnt", {31'd0, s_req}, 32'd1);
        check_eq("lat s_addr", s_addr, A0);
        check_eq("lat busy", {31'd0, busy}, 32'd1);
        tick();
        check_eq("wait m0_ack", {31'd0, m0_ack}, 32'd0);
        tick();
        s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #1;
        check_eq("rd m0_ack", {31'd0, m0_ack}, 32'd1);
        check_eq("rd m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        check_eq("rd m1_ack", {31'd0, m1_ack}, 32'd0);
        tick();
        s_ack = 1'b0; s_rdata = '0; m0_req = 1'b0;
        #1;
        check_eq("rd drain m0_ack", {31'd0, m0_ack}, 32'd0);
        check_eq("rd drain busy", {31'd0, busy}, 32'd0);
        tick();

        // Round-robin from reset: m0, m1, m0, m1.
        rst = 1'b1; tick(); rst = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        do_txn(1'b0, 1'b0, 32'hA000_0001, 1'b0);
        do_txn(1'b1, 1'b0, 32'hA000_0002, 1'b0);
        do_txn(1'b0, 1'b0, 32'hA000_0003, 1'b0);
        do_txn(1'b1, 1'b0, 32'hA000_0004, 1'b0);

        // Debug priority: m1 wins three times, then m0 once m1 drops.
        dbg_priority = 1'b1;
        do_txn(1'b1, 1'b0, 32'hB000_0001, 1'b0);
        do_txn(1'b1, 1'b0, 32'hB000_0002, 1'b0);
        do_txn(1'b1, 1'b0, 32'hB000_0003, 1'b0);
        m1_req = 1'b0;
        do_txn(1'b0, 1'b0, 32'hB000_0004, 1'b0);

        // Slave fault on a debug write.
        dbg_priority = 1'b0; m0_req = 1'b0; m1_req = 1'b1; m1_we = 1'b1;
        do_txn(1'b1, 1'b1, 32'h0, 1'b1);
        m1_req = 1'b0; m1_we = 1'b0;

        // Core drops req mid-grant: grant held, s_req follows req.
        m0_req = 1'b1;
        tick();
        m0_req = 1'b0;
        #1;
        check_eq("drop s_req", {31'd0, s_req}, 32'd0);
        check_eq("drop busy", {31'd0, busy}, 32'd1);
        tick();
        check_eq("drop busy held", {31'd0, busy}, 32'd1);
        s_ack = 1'b1; s_rdata = 32'h0000_00AA;
        #1;
        check_eq("drop m0_ack", {31'd0, m0_ack}, 32'd1);
        tick();
        s_ack = 1'b0; s_rdata = '0;
        tick();

        // Reset during GNT0 abandons the transaction; a later stray ack is ignored.
        m0_req = 1'b1;
        tick();
        check_eq("rstg busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; m0_req = 1'b0;
        #1;
        check_eq("rstg busy", {31'd0, busy}, 32'd0);
        check_eq("rstg s_req", {31'd0, s_req}, 32'd0);
        check_eq("rstg m0_ack", {31'd0, m0_ack}, 32'd0);
        s_ack = 1'b1; s_rdata = 32'h5555_5555;
        #1;
        check_eq("stray m0_ack", {31'd0, m0_ack}, 32'd0);
        check_eq("stray m1_ack", {31'd0, m1_ack}, 32'd0);
        tick();
        s_ack = 1'b0; s_rdata = '0;
        #1;
        check_eq("stray busy", {31'd0, busy}, 32'd0);
        tick();

`ifdef ARILLA_BUS_ARBITER_TIMEOUT_EN
        // Slave never acks m0: fault on the 4th grant cycle, then pending m1 is served.
        rst = 1'b1; tick(); rst = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; s_rdata = 32'h0000_1234;
        tick();
        check_eq("to gnt0", {31'd0, grant_id}, 32'd0);
        tick(); tick();
        check_eq("to early ack", {31'd0, m0_ack}, 32'd0);
        tick();
        check_eq("to m0_ack", {31'd0, m0_ack}, 32'd1);
        check_eq("to m0_fault", {31'd0, m0_fault}, 32'd1);
        check_eq("to m0_rdata", m0_rdata, 32'd0);
        check_eq("to s_req", {31'd0, s_req}, 32'd0);
        tick();
        m0_req = 1'b0; s_rdata = '0;
        #1;
        check_eq("to drain busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        check_eq("to gnt1", {31'd0, grant_id}, 32'd1);
        s_ack = 1'b1;
        #1;
        check_eq("to m1_ack", {31'd0, m1_ack}, 32'd1);
        tick();
        s_ack = 1'b0; m1_req = 1'b0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
